trng_health_fifo: RTL

//  Downstream of the dual-TRNG core: takes 32-bit random words over a ready/read handshake and runs
//  two online health tests on each word. RCT (repetition count) checks for repeated words; APT
//  (monobit proportion) checks the count of 1 bits over a window. Words that pass go into a

---
 rtl/trng_health_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/trng_health_fifo.sv
// rtl/trng_health_fifo.sv - TRNG word capture with RCT/APT online health tests feeding a FWFT FIFO
module trng_health_fifo #(
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 3,
  parameter int APT_WIN    = 8,
  parameter int APT_LO     = 96,
  parameter int APT_HI     = 160
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       src_ready,
  input  logic [31:0]                src_data,
  output logic                       src_read,
  input  logic                       pop,
  output logic [31:0]                dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       rct_fail,
  output logic                       apt_fail,
  output logic                       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = $clog2(APT_WIN * 32 + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int WW = (APT_WIN > 1) ? $clog2(APT_WIN) : 1;

  localparam logic [LW-1:0] DEPTH_V = LW'(DEPTH);
  localparam logic [RW-1:0] CUT_V   = RW'(RCT_CUTOFF);
  localparam logic [RW-1:0] ONE_R   = RW'(1);
  localparam logic [OW-1:0] LO_V    = OW'(APT_LO);
  localparam logic [OW-1:0] HI_V    = OW'(APT_HI);
  localparam logic [WW-1:0] WLAST_V = WW'(APT_WIN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_LOW} state_t;

  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   prev_word;
  logic          have_prev;
  logic [RW-1:0] rep_cnt;
  logic [OW-1:0] ones_acc;
  logic [WW-1:0] win_cnt;

  logic [OW-1:0] popcnt;
  logic [OW-1:0] acc_sum;
  logic [RW-1:0] rep_nxt;
  logic          do_cap, rct_hit, apt_hit, win_last, push, do_pop;

  assign empty = (level == '0);
  assign full  = (level == DEPTH_V);
  assign dout  = empty ? 32'h0 : mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    src_read  = 1'b0;
    case (state)
      IDLE:     if (en && src_ready && !full && !rct_fail && !apt_fail) state_nxt = CAPTURE;
      CAPTURE:  state_nxt = ACK;
      ACK: begin
        src_read  = !clr;
        state_nxt = WAIT_LOW;
      end
      WAIT_LOW: if (!src_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < 32; i++) popcnt = popcnt + OW'(src_data[i]);
  end

  // Tests are evaluated on the word while in CAPTURE; results and push land
  // on the edge into ACK so level is already updated when src_read rises.
  always_comb begin
    do_cap   = (state == CAPTURE);
    rep_nxt  = (have_prev && (src_data == prev_word)) ? rep_cnt + ONE_R : ONE_R;
    rct_hit  = (rep_nxt >= CUT_V);
    acc_sum  = ones_acc + popcnt;
    win_last = (win_cnt == WLAST_V);
    apt_hit  = win_last && ((acc_sum < LO_V) || (acc_sum > HI_V));
    push     = do_cap && !rct_hit && !apt_hit && !full;
    do_pop   = pop && !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rct_fail  <= 1'b0;
      apt_fail  <= 1'b0;
      prev_word <= '0;
      have_prev <= 1'b0;
      rep_cnt   <= '0;
      ones_acc  <= '0;
      win_cnt   <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rct_fail  <= 1'b0;
      apt_fail  <= 1'b0;
      have_prev <= 1'b0;
      rep_cnt   <= '0;
      ones_acc  <= '0;
      win_cnt   <= '0;
    end else begin
      if (do_cap) begin
        prev_word <= src_data;
        have_prev <= 1'b1;
        rep_cnt   <= rep_nxt;
        if (rct_hit) rct_fail <= 1'b1;
        if (apt_hit) apt_fail <= 1'b1;
        if (win_last) begin
          ones_acc <= '0;
          win_cnt  <= '0;
        end else begin
          ones_acc <= acc_sum;
          win_cnt  <= win_cnt + WW'(1);
        end
      end
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)      level <= level + LW'(1);
      else if (!push && do_pop) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= src_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= rct_fail | apt_fail | full;
  end

endmodule
